// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, sequencer state encoding,
// writeback mux selects and trap causes.
package riscv_pkg;

    // Major opcodes (instr[6:0]) recognised by the decoder.
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    // Sequencer states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        SeqFetch     = 3'd0,
        SeqFetchWait = 3'd1,
        SeqDecode    = 3'd2,
        SeqExecute   = 3'd3,
        SeqMem       = 3'd4,
        SeqMemWait   = 3'd5,
        SeqWriteback = 3'd6,
        SeqTrap      = 3'd7
    } seq_state_e;

    // Writeback mux selects (3 is reserved).
    localparam logic [1:0] WbAlu  = 2'd0;
    localparam logic [1:0] WbLoad = 2'd1;
    localparam logic [1:0] WbPc4  = 2'd2;

    typedef enum logic [1:0] {
        TrapNone        = 2'd0,
        TrapIllegal     = 2'd1,
        TrapImemTimeout = 2'd2,
        TrapDmemTimeout = 2'd3
    } trap_cause_e;

    // States in which the sequencer waits on a memory handshake.
    function automatic logic is_wait_state(seq_state_e s);
        return (s == SeqFetch) || (s == SeqFetchWait) ||
               (s == SeqMem)   || (s == SeqMemWait);
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Counts cycles spent in a memory wait state. The current cycle is number
// count+1, so expired rises during the limit-th cycle of the wait; a limit
// of zero disables it.
module seq_timeout_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   cycle_no;

    // Count wait cycles; any state change restarts the count.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign cycle_no = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
    assign expired  = (limit != '0) && (cycle_no == {1'b0, limit});

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback,
// with illegal-opcode / memory-timeout sticky trap and a retire counter.
module core_sequencer
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_avalid,
    input  logic        i_imem_aready,
    input  logic        i_imem_rvalid,
    output logic        o_ir_load,
    input  logic        i_br_en,
    input  logic        i_jump_en,
    input  logic        i_int_en,
    input  logic        i_up_en,
    input  logic        i_load_en,
    input  logic        i_store_en,
    input  logic        i_rd_wvalid,
    input  logic        i_br_taken,
    output logic        o_dmem_avalid,
    output logic        o_dmem_we,
    input  logic        i_dmem_aready,
    input  logic        i_dmem_rvalid,
    output logic        o_rf_we,
    output logic [1:0]  o_wb_sel,
    output logic        o_pc_we,
    output logic        o_pc_sel,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause,
    output logic [63:0] o_instret,
    output logic [2:0]  o_state
);

    localparam logic [CNT_W-1:0] TimeoutLimit = CNT_W'(MEM_TIMEOUT);

    seq_state_e  state, state_next;
    trap_cause_e cause, cause_next;
    logic [63:0] instret;
    logic        timeout_hit;
    logic        retire;

    // Ungated decodes of the current state.
    logic       imem_avalid, ir_load, dmem_avalid, dmem_we;
    logic       rf_we, pc_we, pc_sel, trap;
    logic [1:0] wb_sel;

    seq_timeout_counter #(.CNT_W(CNT_W)) u_timeout (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (state_next != state),
        .enable  (is_wait_state(state)),
        .limit   (TimeoutLimit),
        .expired (timeout_hit)
    );

    // Next-state selection and Moore output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_next  = state;
        cause_next  = cause;
        imem_avalid = 1'b0;
        ir_load     = 1'b0;
        dmem_avalid = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = WbAlu;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        trap        = 1'b0;
        retire      = 1'b0;

        case (state)
            SeqFetch: begin
                imem_avalid = 1'b1;
                // A handshake in the timeout cycle takes priority.
                if (i_imem_aready) begin
                    state_next = SeqFetchWait;
                end else if (timeout_hit) begin
                    state_next = SeqTrap;
                    cause_next = TrapImemTimeout;
                end
            end
            SeqFetchWait: begin
                ir_load = i_imem_rvalid;
                if (i_imem_rvalid) begin
                    state_next = SeqDecode;
                end else if (timeout_hit) begin
                    state_next = SeqTrap;
                    cause_next = TrapImemTimeout;
                end
            end
            SeqDecode: begin
                if (!(i_br_en || i_jump_en || i_int_en || i_up_en ||
                      i_load_en || i_store_en)) begin
                    state_next = SeqTrap;
                    cause_next = TrapIllegal;
                end else begin
                    state_next = SeqExecute;
                end
            end
            SeqExecute: begin
                state_next = (i_load_en || i_store_en) ? SeqMem : SeqWriteback;
            end
            SeqMem: begin
                dmem_avalid = 1'b1;
                dmem_we     = i_store_en;
                if (i_dmem_aready) begin
                    state_next = SeqMemWait;
                end else if (timeout_hit) begin
                    state_next = SeqTrap;
                    cause_next = TrapDmemTimeout;
                end
            end
            SeqMemWait: begin
                if (i_dmem_rvalid) begin
                    state_next = SeqWriteback;
                end else if (timeout_hit) begin
                    state_next = SeqTrap;
                    cause_next = TrapDmemTimeout;
                end
            end
            SeqWriteback: begin
                pc_we      = 1'b1;
                pc_sel     = i_jump_en || (i_br_en && i_br_taken);
                rf_we      = i_rd_wvalid && !i_store_en && !i_br_en;
                wb_sel     = i_load_en ? WbLoad : (i_jump_en ? WbPc4 : WbAlu);
                retire     = 1'b1;
                state_next = SeqFetch;
            end
            SeqTrap: begin
                trap = 1'b1;
            end
            default: begin
                state_next = SeqFetch;
            end
        endcase
    end

    // State, first trap cause and retire counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= SeqFetch;
            cause   <= TrapNone;
            instret <= '0;
        end else begin
            state <= state_next;
            cause <= cause_next;
            if (retire) begin
                instret <= instret + 64'd1;
            end
        end
    end

    // Every output is held low while reset is asserted.
    assign o_imem_avalid = imem_avalid && !i_rst;
    assign o_ir_load     = ir_load     && !i_rst;
    assign o_dmem_avalid = dmem_avalid && !i_rst;
    assign o_dmem_we     = dmem_we     && !i_rst;
    assign o_rf_we       = rf_we       && !i_rst;
    assign o_pc_we       = pc_we       && !i_rst;
    assign o_pc_sel      = pc_sel      && !i_rst;
    assign o_trap        = trap        && !i_rst;
    assign o_wb_sel      = i_rst ? 2'd0  : wb_sel;
    assign o_trap_cause  = i_rst ? 2'd0  : cause;
    assign o_instret     = i_rst ? 64'd0 : instret;
    assign o_state       = i_rst ? 3'd0  : state;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. The expected cycle-by-cycle trace
// of each instruction is built from its class and the memory delays chosen.
module tb_core_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_imem_aready, i_imem_rvalid;
    logic        i_br_en, i_jump_en, i_int_en, i_up_en, i_load_en, i_store_en;
    logic        i_rd_wvalid, i_br_taken, i_dmem_aready, i_dmem_rvalid;

    logic        o_imem_avalid, o_ir_load, o_dmem_avalid, o_dmem_we, o_rf_we;
    logic        o_pc_we, o_pc_sel, o_trap;
    logic [1:0]  o_wb_sel, o_trap_cause;
    logic [63:0] o_instret;
    logic [2:0]  o_state;

    logic        b_imem_avalid, b_ir_load, b_dmem_avalid, b_dmem_we, b_rf_we;
    logic        b_pc_we, b_pc_sel, b_trap;
    logic [1:0]  b_wb_sel, b_trap_cause;
    logic [63:0] b_instret;
    logic [2:0]  b_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] instret_exp = '0;

    always #5 i_clk = ~i_clk;

    core_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_avalid(o_imem_avalid), .i_imem_aready(i_imem_aready),
        .i_imem_rvalid(i_imem_rvalid), .o_ir_load(o_ir_load),
        .i_br_en(i_br_en), .i_jump_en(i_jump_en), .i_int_en(i_int_en),
        .i_up_en(i_up_en), .i_load_en(i_load_en), .i_store_en(i_store_en),
        .i_rd_wvalid(i_rd_wvalid), .i_br_taken(i_br_taken),
        .o_dmem_avalid(o_dmem_avalid), .o_dmem_we(o_dmem_we),
        .i_dmem_aready(i_dmem_aready), .i_dmem_rvalid(i_dmem_rvalid),
        .o_rf_we(o_rf_we), .o_wb_sel(o_wb_sel), .o_pc_we(o_pc_we),
        .o_pc_sel(o_pc_sel), .o_trap(o_trap), .o_trap_cause(o_trap_cause),
        .o_instret(o_instret), .o_state(o_state)
    );

    core_sequencer #(.MEM_TIMEOUT(4), .CNT_W(8)) dut_to (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_avalid(b_imem_avalid), .i_imem_aready(i_imem_aready),
        .i_imem_rvalid(i_imem_rvalid), .o_ir_load(b_ir_load),
        .i_br_en(i_br_en), .i_jump_en(i_jump_en), .i_int_en(i_int_en),
        .i_up_en(i_up_en), .i_load_en(i_load_en), .i_store_en(i_store_en),
        .i_rd_wvalid(i_rd_wvalid), .i_br_taken(i_br_taken),
        .o_dmem_avalid(b_dmem_avalid), .o_dmem_we(b_dmem_we),
        .i_dmem_aready(i_dmem_aready), .i_dmem_rvalid(i_dmem_rvalid),
        .o_rf_we(b_rf_we), .o_wb_sel(b_wb_sel), .o_pc_we(b_pc_we),
        .o_pc_sel(b_pc_sel), .o_trap(b_trap), .o_trap_cause(b_trap_cause),
        .o_instret(b_instret), .o_state(b_state)
    );

    // Packed output vector: state, imem_avalid, ir_load, dmem_avalid,
    // dmem_we, rf_we, wb_sel, pc_we, pc_sel, trap.
    function automatic logic [12:0] vec(input logic [2:0] st, input logic iav,
                                        input logic irl, input logic dav,
                                        input logic dwe, input logic rfwe,
                                        input logic [1:0] wbs, input logic pcwe,
                                        input logic pcsel, input logic trp);
        return {st, iav, irl, dav, dwe, rfwe, wbs, pcwe, pcsel, trp};
    endfunction

    function automatic logic [12:0] obs_a();
        return {o_state, o_imem_avalid, o_ir_load, o_dmem_avalid, o_dmem_we,
                o_rf_we, o_wb_sel, o_pc_we, o_pc_sel, o_trap};
    endfunction

    function automatic logic [12:0] obs_b();
        return {b_state, b_imem_avalid, b_ir_load, b_dmem_avalid, b_dmem_we,
                b_rf_we, b_wb_sel, b_pc_we, b_pc_sel, b_trap};
    endfunction

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at posedge+1: let inputs settle, compare, advance one cycle.
    task automatic cyc(input string tag, input logic [12:0] expected);
        #1;
        check(tag, 64'(obs_a()), 64'(expected));
        check({tag, " instret"}, o_instret, instret_exp);
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_imem_aready = 1'b0; i_imem_rvalid = 1'b0;
        i_dmem_aready = 1'b0; i_dmem_rvalid = 1'b0;
        {i_br_en, i_jump_en, i_int_en, i_up_en, i_load_en, i_store_en} = '0;
        i_rd_wvalid = 1'b0; i_br_taken = 1'b0;
    endtask

    // Two reset cycles with all outputs forced low, then release.
    task automatic do_reset();
        clear_inputs();
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        check("reset outputs", 64'({obs_a(), o_trap_cause}), 64'd0);
        check("reset instret", o_instret, 64'd0);
        i_rst = 1'b0;
        instret_exp = '0;
    endtask

    // One instruction. cls: 0 br, 1 jump, 2 int, 3 upper, 4 load, 5 store,
    // 6 no class flag. fa = cycles before imem accept, fr = fetch-wait cycles
    // (rvalid in the last), da/dr likewise for the data side.
    task automatic run_instr(input int cls, input logic taken, input logic rdw,
                             input int fa, input int fr, input int da,
                             input int dr, input string name);
        logic [5:0] f;
        logic       is_br, is_jmp, is_ld, is_st, pcsel, rfwe;
        logic [1:0] wbs;
        f = '0;
        if (cls < 6) f[5-cls] = 1'b1;
        {i_br_en, i_jump_en, i_int_en, i_up_en, i_load_en, i_store_en} = f;
        i_br_taken  = taken;
        i_rd_wvalid = rdw;
        is_br  = (cls == 0);
        is_jmp = (cls == 1);
        is_ld  = (cls == 4);
        is_st  = (cls == 5);
        pcsel  = is_jmp | (is_br & taken);
        rfwe   = rdw & ~is_st & ~is_br;
        wbs    = is_ld ? 2'd1 : (is_jmp ? 2'd2 : 2'd0);

        for (int c = 0; c <= fa; c++) begin
            i_imem_aready = (c == fa);
            cyc({name, " fetch"}, vec(3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0));
        end
        i_imem_aready = 1'b0;
        for (int c = 1; c <= fr; c++) begin
            i_imem_rvalid = (c == fr);
            cyc({name, " fetch_wait"}, vec(3'd1, 0, (c == fr), 0, 0, 0, 2'd0, 0, 0, 0));
        end
        i_imem_rvalid = 1'b0;
        cyc({name, " decode"}, vec(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
        if (cls == 6) return;
        cyc({name, " execute"}, vec(3'd3, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
        if (is_ld || is_st) begin
            for (int c = 0; c <= da; c++) begin
                i_dmem_aready = (c == da);
                cyc({name, " mem"}, vec(3'd4, 0, 0, 1, is_st, 0, 2'd0, 0, 0, 0));
            end
            i_dmem_aready = 1'b0;
            for (int c = 1; c <= dr; c++) begin
                i_dmem_rvalid = (c == dr);
                cyc({name, " mem_wait"}, vec(3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
            end
            i_dmem_rvalid = 1'b0;
        end
        cyc({name, " writeback"}, vec(3'd6, 0, 0, 0, 0, rfwe, wbs, 1, pcsel, 0));
        instret_exp = instret_exp + 64'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        i_rst = 1'b1;
        do_reset();

        // Directed instructions.
        run_instr(2, 1'b0, 1'b1, 0, 1, 0, 1, "addi");
        run_instr(4, 1'b0, 1'b1, 0, 1, 3, 2, "lw");
        run_instr(5, 1'b0, 1'b1, 0, 1, 0, 1, "sw");
        run_instr(0, 1'b1, 1'b1, 0, 1, 0, 1, "beq_taken");
        run_instr(0, 1'b0, 1'b1, 0, 1, 0, 1, "beq_not_taken");
        run_instr(1, 1'b0, 1'b1, 0, 1, 0, 1, "jal");
        run_instr(3, 1'b0, 1'b1, 2, 2, 0, 1, "lui");

        // Illegal opcode: sticky trap, requests ignored, only reset exits.
        run_instr(6, 1'b0, 1'b1, 0, 1, 0, 1, "illegal");
        for (int c = 0; c < 4; c++) begin
            i_imem_aready = 1'b1;
            i_dmem_aready = 1'b1;
            #1;
            check("illegal trap cause", 64'(o_trap_cause), 64'd1);
            cyc("illegal trap", vec(3'd7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1));
        end
        do_reset();
        #1;
        check("post-reset state", 64'(o_state), 64'd0);
        check("post-reset instret", o_instret, 64'd0);
        check("post-reset trap", 64'({o_trap, o_trap_cause}), 64'd0);

        // Randomised instruction stream with short memory waits.
        for (int n = 0; n < 40; n++) begin
            run_instr(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      int'($urandom_range(1, 2)), int'($urandom_range(0, 2)),
                      int'($urandom_range(1, 2)), "rand");
        end

        // MEM_TIMEOUT=4, fetch never accepted: trap after the 4th FETCH cycle.
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("to4 fetch wait", 64'(obs_b()), 64'(vec(3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0)));
            @(posedge i_clk); #1;
        end
        #1;
        check("to4 imem trap", 64'(obs_b()), 64'(vec(3'd7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1)));
        check("to4 imem cause", 64'(b_trap_cause), 64'd2);

        // MEM_TIMEOUT=4, accept on the 4th cycle: handshake wins.
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            i_imem_aready = (c == 4);
            #1;
            check("to4 late accept fetch", 64'(obs_b()), 64'(vec(3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0)));
            @(posedge i_clk); #1;
        end
        i_imem_aready = 1'b0;
        #1;
        check("to4 late accept", 64'(obs_b()), 64'(vec(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0)));
        check("to4 late accept cause", 64'(b_trap_cause), 64'd0);

        // MEM_TIMEOUT=4, load whose data request is never accepted.
        do_reset();
        i_load_en = 1'b1;
        i_imem_aready = 1'b1;
        @(posedge i_clk); #1;
        i_imem_aready = 1'b0;
        i_imem_rvalid = 1'b1;
        @(posedge i_clk); #1;
        i_imem_rvalid = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("to4 dmem wait", 64'(obs_b()), 64'(vec(3'd4, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0)));
            @(posedge i_clk); #1;
        end
        #1;
        check("to4 dmem trap", 64'(obs_b()), 64'(vec(3'd7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1)));
        check("to4 dmem cause", 64'(b_trap_cause), 64'd3);
        check("to4 instret", b_instret, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
